bound_flasher_gen: RTL

Parametrised successor to the 16-LED bound flasher. Drives a thermometer-coded LED bar of NUM_LED lamps through a programmable table of up to MAX_STEPS waypoints, with an optional loop mode. Flick handling is fully synchronous and supports restart-on-flick at configurable kick-back positions. Includes a hold (pause) input. Sits between the board debouncer (flick, hold) and the LED pad drivers; the CPU/testbench writes the waypoint table.

---
 rtl/bound_flasher_pkg.sv | 27 ++
 rtl/bf_waypoint_table.sv | 66 ++++++
 rtl/bound_flasher_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared constants for the parametrised bound flasher: state encoding,
// power-on waypoint table and the address of the len/loop register.
package bound_flasher_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int   DEF_LEN  = 6;
    localparam logic DEF_LOOP = 1'b0;

    // Power-on waypoints: full, kick, two-thirds, empty, kick, empty.
    function automatic int default_target(input int idx, input int num_led, input int kick_pos);
        case (idx)
            0:       return num_led;
            1:       return kick_pos;
            2:       return (2 * num_led) / 3;
            4:       return kick_pos;
            default: return 0;
        endcase
    endfunction

    // The len/loop register sits just past the last target slot.
    function automatic int len_reg_addr(input int max_steps);
        return max_steps;
    endfunction

endpackage

// File: rtl/bf_waypoint_table.sv
// Waypoint register file: clamps writes, resets to the default table and
// reads the current and following waypoint combinationally.
module bf_waypoint_table
    import bound_flasher_pkg::*;
#(
    parameter int NUM_LED   = 16,
    parameter int MAX_STEPS = 8,
    parameter int KICK_POS  = NUM_LED / 3,
    parameter int CNT_W     = $clog2(NUM_LED + 1),
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [STEP_W:0]   addr,
    input  logic [CNT_W:0]    wdata,
    input  logic [STEP_W-1:0] step_idx,
    output logic [CNT_W-1:0]  tgt_cur,
    output logic [CNT_W-1:0]  tgt_nxt,
    output logic              last,
    output logic              loop_en
);

    localparam int LEN_W = STEP_W + 1;

    logic [CNT_W-1:0]  tgt [MAX_STEPS];
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_clamped;
    logic [CNT_W-1:0]  tgt_clamped;
    logic [STEP_W-1:0] nxt_idx;
    int                len_fld;

    always_comb begin
        len_fld = int'(wdata[CNT_W-1:0]);
        if (len_fld == 0)
            len_clamped = LEN_W'(1);
        else if (len_fld > MAX_STEPS)
            len_clamped = LEN_W'(MAX_STEPS);
        else
            len_clamped = LEN_W'(len_fld);
        tgt_clamped = (int'(wdata) > NUM_LED) ? CNT_W'(NUM_LED) : wdata[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STEPS; i++)
                tgt[i] <= CNT_W'(default_target(i, NUM_LED, KICK_POS));
            len     <= LEN_W'(DEF_LEN);
            loop_en <= DEF_LOOP;
        end else if (we) begin
            if (int'(addr) == len_reg_addr(MAX_STEPS)) begin
                len     <= len_clamped;
                loop_en <= wdata[CNT_W];
            end else if (int'(addr) < MAX_STEPS) begin
                tgt[addr[STEP_W-1:0]] <= tgt_clamped;
            end
        end
    end

    // Next index wraps to 0 after the last step so loop mode reuses tgt_nxt.
    assign last    = ({1'b0, step_idx} == (len - LEN_W'(1)));
    assign nxt_idx = last ? '0 : step_idx + STEP_W'(1);
    assign tgt_cur = tgt[step_idx];
    assign tgt_nxt = tgt[nxt_idx];

endmodule

// File: rtl/bound_flasher_gen.sv
// Bound flasher top: walks a thermometer LED bar through the waypoint table,
// with hold, kick-back on flick and optional looping.
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int NUM_LED   = 16,
    parameter int MAX_STEPS = 8,
    parameter int KICK_POS  = NUM_LED / 3,
    parameter int CNT_W     = $clog2(NUM_LED + 1),
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flick,
    input  logic               hold,
    input  logic               cfg_we,
    input  logic [STEP_W:0]    cfg_addr,
    input  logic [CNT_W:0]     cfg_wdata,
    output logic [NUM_LED-1:0] led,
    output logic [CNT_W-1:0]   lit_cnt,
    output logic [STEP_W-1:0]  step_idx,
    output logic               dir_down,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    logic [0:0]       state;
    logic [CNT_W-1:0] tgt_cur;
    logic [CNT_W-1:0] tgt_nxt;
    logic             last;
    logic             loop_en;
    logic             bad_addr;
    logic             wr_en;
    logic             kick;

    function automatic logic [CNT_W-1:0] toward(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] t);
        if (t > c)
            return c + CNT_W'(1);
        else if (t < c)
            return c - CNT_W'(1);
        else
            return c;
    endfunction

    assign bad_addr = (cfg_addr > (STEP_W + 1)'(MAX_STEPS));
    assign wr_en    = cfg_we && (state == IDLE) && !bad_addr;

    bf_waypoint_table #(
        .NUM_LED  (NUM_LED),
        .MAX_STEPS(MAX_STEPS),
        .KICK_POS (KICK_POS),
        .CNT_W    (CNT_W),
        .STEP_W   (STEP_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .addr    (cfg_addr),
        .wdata   (cfg_wdata),
        .step_idx(step_idx),
        .tgt_cur (tgt_cur),
        .tgt_nxt (tgt_nxt),
        .last    (last),
        .loop_en (loop_en)
    );

    // Kick-back only from a downward segment that is not the final one.
    assign kick = flick && dir_down && (step_idx != '0) && !last &&
                  ((lit_cnt == '0) || (lit_cnt == CNT_W'(KICK_POS)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lit_cnt  <= '0;
            step_idx <= '0;
            dir_down <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_we && ((state == RUN) || bad_addr);
            case (state)
                IDLE: begin
                    lit_cnt  <= '0;
                    step_idx <= '0;
                    dir_down <= 1'b0;
                    if (flick) begin
                        state   <= RUN;
                        lit_cnt <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (kick) begin
                            step_idx <= step_idx - STEP_W'(1);
                            dir_down <= 1'b0;
                            lit_cnt  <= toward(lit_cnt, CNT_W'(NUM_LED));
                        end else if (lit_cnt != tgt_cur) begin
                            lit_cnt  <= toward(lit_cnt, tgt_cur);
                            dir_down <= (tgt_cur < lit_cnt);
                        end else if (!last || loop_en) begin
                            // No dwell: step and first move happen together.
                            step_idx <= last ? '0 : step_idx + STEP_W'(1);
                            lit_cnt  <= toward(lit_cnt, tgt_nxt);
                            dir_down <= (tgt_nxt < lit_cnt);
                        end else begin
                            state    <= IDLE;
                            lit_cnt  <= '0;
                            step_idx <= '0;
                            dir_down <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        assign led[i] = (CNT_W'(i) < lit_cnt);
    end

endmodule
